tx_req_responder_trico: RTL
===========================

Name: tx_req_responder_trico

Overview:
Responder end of the trico TX scheduler request/status protocol. It accepts transmit requests (queue, tag, dest) from the scheduler and tracks per-queue pending packet counts and lengths by snooping the same doorbell stream the scheduler sees. After a fixed latency it returns a status (len, tag) to the scheduler: the packet length when the queue had a packet, or len=0 when it was empty. It is the TX-engine stand-in used for bring-up and for scheduler verification.

Parameters:
QUEUE_INDEX_WIDTH, 6, queue index width; table depth is 2**QUEUE_INDEX_WIDTH.
REQ_TAG_WIDTH, 8, request/status tag width.
AXIS_TX_DEST_WIDTH, 5, request dest width; dest is accepted and ignored.
LEN_WIDTH, 16, status length width.
PACKET_WIDTH, 7, doorbell pkt_length width, in units of 2**LEN_SHIFT bytes.
LEN_SHIFT, 6, left shift applied to pkt_length to form bytes.
COUNT_WIDTH, 8, per-queue pending packet counter width.
RESP_DELAY, 4, request-accept to status-valid latency in cycles, at least 1.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
s_axis_tx_req_queue  in  QUEUE_INDEX_WIDTH  requested queue
s_axis_tx_req_tag  in  REQ_TAG_WIDTH  request tag
s_axis_tx_req_dest  in  AXIS_TX_DEST_WIDTH  dest, ignored
s_axis_tx_req_valid  in  1  request valid
s_axis_tx_req_ready  out  1  request ready
s_axis_doorbell_queue  in  QUEUE_INDEX_WIDTH  doorbell queue
s_axis_doorbell_pkt_length  in  PACKET_WIDTH  packet length in units
s_axis_doorbell_valid  in  1  doorbell strobe; no ready
m_axis_tx_req_status_len  out  LEN_WIDTH  bytes; 0 means queue empty
m_axis_tx_req_status_tag  out  REQ_TAG_WIDTH  echoed tag
m_axis_tx_req_status_valid  out  1  single-cycle strobe; no backpressure
enable  in  1  when low, no new requests are accepted
stat_req_count  out  32  accepted requests, wrapping
stat_empty_count  out  32  len=0 responses, wrapping
overflow  out  1  sticky; a doorbell hit a saturated counter
busy  out  1  in INIT or delay line non-empty

Behaviour:
- Reset values: ready=0, status_valid=0, len=0, tag=0, stats=0, overflow=0. State enters INIT; the delay line is cleared.
- States:
  - INIT: sweeps address 0..2**QUEUE_INDEX_WIDTH-1, one entry per cycle, writing count=0 and len=0. Moves to RUN after the last entry (2**QUEUE_INDEX_WIDTH cycles). Doorbells during INIT are dropped.
  - RUN: normal operation.
- ready = (state==RUN) && enable. A handshake is valid && ready. Deasserting enable does not affect in-flight responses.
- Accept: read count[q].
  - If count>0, decrement it and set len = max(pkt_length,1) << LEN_SHIFT (zero-extended, truncated to LEN_WIDTH).
  - Otherwise len=0 and stat_empty_count increments.
  - stat_req_count increments on every accept.
- Doorbell in RUN: count[q] increments and len[q] is overwritten with the new pkt_length (latest-wins, one length per queue). At the max count value the count holds, len still updates, and overflow is set.
- Same-cycle doorbell and request on the same queue: the request sees the pre-doorbell count. The net count update is +1-(count>0), and the status uses the pre-doorbell length. Different queues update independently.
- Delay line: a RESP_DELAY-stage shift register of {valid, len, tag}. Status appears exactly RESP_DELAY cycles after the accept cycle. Back-to-back accepts give back-to-back statuses in order.
- Table update is single-cycle read-modify-write, with no forwarding hazard: each cycle performs at most one request and one doorbell, merged into the per-queue update.
- Reset mid-operation: pending statuses are discarded (no status strobe after rst), tables are re-initialised via INIT, and stats and overflow are cleared.

Test Plan:
- Reset, QUEUE_INDEX_WIDTH=6 -> ready stays 0 for 64 cycles, ready=1 at cycle 64 with enable=1, busy=1 during INIT.
- Doorbell q=5 len=10, then request q=5 tag=0x3A -> status tag=0x3A len=640 exactly 4 cycles after accept; a second request to q=5 -> len=0, stat_empty_count=1.
- Doorbell and request to q=2 (count 0) in the same cycle -> status len=0; a following request to q=2 -> len=(pkt_length<<6); stat_req_count=2.
- 256 doorbells to q=1 with COUNT_WIDTH=8 -> overflow=1, count holds at 255; then 255 requests return nonzero len and the 256th returns len=0.
- Doorbell pkt_length=0 then request -> len=64. 8 back-to-back requests tags 0..7 -> 8 consecutive status strobes with tags 0..7 in order.
- Assert rst with 3 statuses in flight -> no status_valid afterwards, stats=0, and a request after INIT to a previously filled queue returns len=0.

Source files
------------

// File: rtl/tx_req_responder_trico.sv
// Responder end of the trico TX scheduler request/status protocol: snoops doorbells
// into per-queue count/length tables and answers each request after a fixed delay.
module tx_req_responder_trico #(
  parameter int unsigned QUEUE_INDEX_WIDTH  = 6,
  parameter int unsigned REQ_TAG_WIDTH      = 8,
  parameter int unsigned AXIS_TX_DEST_WIDTH = 5,
  parameter int unsigned LEN_WIDTH          = 16,
  parameter int unsigned PACKET_WIDTH       = 7,
  parameter int unsigned LEN_SHIFT          = 6,
  parameter int unsigned COUNT_WIDTH        = 8,
  parameter int unsigned RESP_DELAY         = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [QUEUE_INDEX_WIDTH-1:0]  s_axis_tx_req_queue,
  input  logic [REQ_TAG_WIDTH-1:0]      s_axis_tx_req_tag,
  input  logic [AXIS_TX_DEST_WIDTH-1:0] s_axis_tx_req_dest,
  input  logic                          s_axis_tx_req_valid,
  output logic                          s_axis_tx_req_ready,
  input  logic [QUEUE_INDEX_WIDTH-1:0]  s_axis_doorbell_queue,
  input  logic [PACKET_WIDTH-1:0]       s_axis_doorbell_pkt_length,
  input  logic                          s_axis_doorbell_valid,
  output logic [LEN_WIDTH-1:0]          m_axis_tx_req_status_len,
  output logic [REQ_TAG_WIDTH-1:0]      m_axis_tx_req_status_tag,
  output logic                          m_axis_tx_req_status_valid,
  input  logic                          enable,
  output logic [31:0]                   stat_req_count,
  output logic [31:0]                   stat_empty_count,
  output logic                          overflow,
  output logic                          busy
);

  localparam int unsigned DEPTH  = 2 ** QUEUE_INDEX_WIDTH;
  localparam int unsigned WIDE_W = LEN_WIDTH + PACKET_WIDTH + LEN_SHIFT;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                         state, state_next;
  logic [QUEUE_INDEX_WIDTH-1:0]   init_addr;
  logic [COUNT_WIDTH-1:0]         count_mem [DEPTH];
  logic [PACKET_WIDTH-1:0]        len_mem   [DEPTH];

  logic                           accept, db_hit, same_q, req_has_pkt, db_sat;
  logic [COUNT_WIDTH-1:0]         req_cnt, db_cnt;
  logic [PACKET_WIDTH-1:0]        req_len, pkt_units;
  logic [WIDE_W-1:0]              len_wide;
  logic [LEN_WIDTH-1:0]           resp_len;

  logic [RESP_DELAY-1:0]          dl_valid;
  logic [LEN_WIDTH-1:0]           dl_len [RESP_DELAY];
  logic [REQ_TAG_WIDTH-1:0]       dl_tag [RESP_DELAY];

  logic                           unused_dest;
  assign unused_dest = ^s_axis_tx_req_dest;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_INIT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_INIT: if (init_addr == '1) state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || state != ST_INIT) init_addr <= '0;
    else                         init_addr <= init_addr + 1'b1;
  end

  assign s_axis_tx_req_ready = (state == ST_RUN) && enable;
  assign accept  = s_axis_tx_req_valid && s_axis_tx_req_ready;
  assign db_hit  = s_axis_doorbell_valid && (state == ST_RUN);
  assign same_q  = accept && db_hit && (s_axis_tx_req_queue == s_axis_doorbell_queue);

  assign req_cnt     = count_mem[s_axis_tx_req_queue];
  assign req_len     = len_mem[s_axis_tx_req_queue];
  assign db_cnt      = count_mem[s_axis_doorbell_queue];
  assign req_has_pkt = (req_cnt != '0);
  assign db_sat      = (db_cnt == '1);
  assign pkt_units   = (req_len == '0) ? PACKET_WIDTH'(1) : req_len;
  assign len_wide    = WIDE_W'(pkt_units) << LEN_SHIFT;
  assign resp_len    = req_has_pkt ? len_wide[LEN_WIDTH-1:0] : '0;

  // Same-queue request+doorbell is merged into one write; being last, it overrides the decrement.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      count_mem[init_addr] <= '0;
      len_mem[init_addr]   <= '0;
    end else begin
      if (accept && req_has_pkt)
        count_mem[s_axis_tx_req_queue] <= req_cnt - COUNT_WIDTH'(1);
      if (db_hit) begin
        len_mem[s_axis_doorbell_queue] <= s_axis_doorbell_pkt_length;
        if (same_q)
          count_mem[s_axis_doorbell_queue] <= req_has_pkt ? req_cnt : req_cnt + COUNT_WIDTH'(1);
        else if (!db_sat)
          count_mem[s_axis_doorbell_queue] <= db_cnt + COUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow         <= 1'b0;
      stat_req_count   <= '0;
      stat_empty_count <= '0;
    end else begin
      if (db_hit && db_sat && !same_q) overflow <= 1'b1;
      if (accept) stat_req_count <= stat_req_count + 32'd1;
      if (accept && !req_has_pkt) stat_empty_count <= stat_empty_count + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dl_valid <= '0;
      for (int unsigned i = 0; i < RESP_DELAY; i++) begin
        dl_len[i] <= '0;
        dl_tag[i] <= '0;
      end
    end else begin
      dl_valid[0] <= accept;
      dl_len[0]   <= accept ? resp_len : '0;
      dl_tag[0]   <= accept ? s_axis_tx_req_tag : '0;
      for (int unsigned i = 1; i < RESP_DELAY; i++) begin
        dl_valid[i] <= dl_valid[i-1];
        dl_len[i]   <= dl_len[i-1];
        dl_tag[i]   <= dl_tag[i-1];
      end
    end
  end

  assign m_axis_tx_req_status_valid = dl_valid[RESP_DELAY-1];
  assign m_axis_tx_req_status_len   = dl_len[RESP_DELAY-1];
  assign m_axis_tx_req_status_tag   = dl_tag[RESP_DELAY-1];
  assign busy = (state == ST_INIT) || (|dl_valid);

endmodule
